// File: rtl/register_5bit_pkg.sv
// Shared constants and the default data word type for the register_5bit
// holding/pipeline register and its stage sub-module.
package register_5bit_pkg;

  localparam int REG_DEFAULT_WIDTH = 5;

  typedef logic [REG_DEFAULT_WIDTH-1:0] reg_word_t;

  localparam reg_word_t REG_DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/register_stage.sv
// One WIDTH-bit flop with asynchronous active-low reset to RESET_VAL.
// Building block for the register_5bit stage chain.
module register_stage
  import register_5bit_pkg::*;
#(
  parameter int               WIDTH     = REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on every rising edge; force RESET_VAL while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignment so every stage samples its neighbour's
    // pre-edge value and the chain shifts by exactly one position per edge.
    if (!rst) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_5bit.sv
// Clocked data register: DEPTH cascaded WIDTH-bit stages, no enable.
// data_in sampled at edge N appears on data_out after edge N + DEPTH - 1.
// Optional build macro REGISTER_5BIT_PARITY_EN adds parity_out, the even
// parity (XOR) of data_out, registered alongside the last stage.
module register_5bit
  import register_5bit_pkg::*;
#(
  parameter int          WIDTH     = REG_DEFAULT_WIDTH,
  parameter int          DEPTH     = 1,
  // Held in a wide container so a value too large for WIDTH can be
  // detected at elaboration instead of being silently truncated.
  parameter logic [63:0] RESET_VAL = 64'(REG_DEFAULT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef REGISTER_5BIT_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(RESET_VAL);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("register_5bit: WIDTH must be at least 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("register_5bit: DEPTH must be at least 1");
  end
  if (WIDTH < 64) begin : g_reset_fit
    if ((RESET_VAL >> WIDTH) != 64'd0) begin : g_bad_reset_val
      $error("register_5bit: RESET_VAL does not fit in WIDTH bits");
    end
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (k == 0) begin : g_head
      assign stage_d = data_in;
    end else begin : g_link
      assign stage_d = stage_q[k-1];
    end

    register_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_WORD)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d   (stage_d),
      .q   (stage_q[k])
    );
  end

  assign data_out = stage_q[DEPTH-1];

`ifdef REGISTER_5BIT_PARITY_EN
  logic parity_q;

  // Parity is computed from the last stage's input so it lands on the same
  // edge as data_out and shares its latency and reset behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= ^RESET_WORD;
    end else begin
      parity_q <= ^g_stage[DEPTH-1].stage_d;
    end
  end

  assign parity_out = parity_q;
`endif

  // An unknown reset level is a board/bench error, not a design state.
  a_rst_known: assert property (@(posedge clk) !$isunknown(rst));

endmodule

// File: tb/tb_register_5bit.sv
// Scoreboard bench for register_5bit: a default instance (WIDTH 5, DEPTH 1,
// RESET_VAL 0) and a DEPTH 3 / RESET_VAL 5'h1F instance. The driver pushes
// hand-computed expectations and raises sample_ev; the monitor pops and
// compares. Parity checks are compiled in with REGISTER_5BIT_PARITY_EN.
module tb_register_5bit;

  typedef struct {
    string      name;
    int         which;   // 0 default data, 1 deep data, 2 default parity
    logic [4:0] exp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] data_in;
  logic [4:0] data_out;
  logic       rst_d;
  logic [4:0] data_in_d;
  logic [4:0] data_out_d;
`ifdef REGISTER_5BIT_PARITY_EN
  logic       parity_out;
  logic       parity_out_d;
`endif

  exp_t sb_q[$];
  event sample_ev;
  int   n_pass  = 0;
  int   n_total = 0;

  register_5bit u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out)
`ifdef REGISTER_5BIT_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  register_5bit #(
    .WIDTH     (5),
    .DEPTH     (3),
    .RESET_VAL (64'h1F)
  ) u_deep (
    .clk        (clk),
    .rst        (rst_d),
    .data_in    (data_in_d),
    .data_out   (data_out_d)
`ifdef REGISTER_5BIT_PARITY_EN
    ,
    .parity_out (parity_out_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_val(input int which, input string name, input logic [4:0] exp);
    sb_q.push_back('{name, which, exp});
    -> sample_ev;
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the current outputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.which)
          0: check(e.name, data_out, e.exp);
          1: check(e.name, data_out_d, e.exp);
`ifdef REGISTER_5BIT_PARITY_EN
          2: check(e.name, {4'b0, parity_out}, e.exp);
`endif
          default: check(e.name, 5'bxxxxx, e.exp);
        endcase
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [4:0] model;

    rst       = 1'b0;
    data_in   = 5'b10110;
    rst_d     = 1'b0;
    data_in_d = 5'h0A;

    // Reset at start: output held at 0 across three edges.
    #1;
    expect_val(0, "reset_initial", 5'b00000);
`ifdef REGISTER_5BIT_PARITY_EN
    expect_val(2, "parity_in_reset", 5'b00000);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val(0, "reset_hold_edge", 5'b00000);
    end
    expect_val(1, "deep_in_reset", 5'h1F);

    // Release between edges: no capture until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_val(0, "release_no_capture", 5'b00000);
    tick();
    expect_val(0, "first_capture", 5'b10110);
`ifdef REGISTER_5BIT_PARITY_EN
    expect_val(2, "parity_10110", 5'b00001);
    @(negedge clk);
    data_in = 5'b10100;
    tick();
    expect_val(0, "capture_10100", 5'b10100);
    expect_val(2, "parity_10100", 5'b00000);
`endif

    // Capture sequence, one value per edge.
    @(negedge clk);
    data_in = 5'b00001;
    tick();
    expect_val(0, "capture_00001", 5'b00001);
    @(negedge clk);
    data_in = 5'b11111;
    tick();
    expect_val(0, "capture_11111", 5'b11111);
    @(negedge clk);
    data_in = 5'b01010;
    tick();
    expect_val(0, "capture_01010", 5'b01010);

    // data_in changing between edges does not reach data_out.
    #2;
    data_in = 5'b10001;
    #1;
    expect_val(0, "no_change_between_edges", 5'b01010);

    // Async reset halfway between edges.
    @(negedge clk);
    data_in = 5'b11011;
    tick();
    expect_val(0, "capture_11011", 5'b11011);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_val(0, "async_clear", 5'b00000);
`ifdef REGISTER_5BIT_PARITY_EN
    expect_val(2, "parity_async_clear", 5'b00000);
`endif
    #1;
    rst     = 1'b1;
    data_in = 5'b00100;
    #1;
    expect_val(0, "after_release_pre_edge", 5'b00000);
    tick();
    expect_val(0, "capture_after_reset", 5'b00100);

    // Random soak against a simple model: async clear, capture on posedge.
    @(negedge clk);
    rst     = 1'b1;
    data_in = 5'b00000;
    tick();
    model = 5'b00000;
    expect_val(0, "soak_start", model);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_in = 5'($urandom);
      rst     = ($urandom_range(0, 3) != 0);
      #1;
      if (!rst) model = 5'b00000;
      expect_val(0, "soak_mid", model);
      tick();
      if (rst) model = data_in;
      expect_val(0, "soak_edge", model);
`ifdef REGISTER_5BIT_PARITY_EN
      expect_val(2, "soak_parity", {4'b0, ^model});
`endif
    end

    // DEPTH 3, RESET_VAL 5'h1F: reset value, then two fill edges.
    expect_val(1, "deep_still_in_reset", 5'h1F);
    @(negedge clk);
    rst_d     = 1'b1;
    data_in_d = 5'h03;
    tick();
    expect_val(1, "deep_fill_1", 5'h1F);
    @(negedge clk);
    data_in_d = 5'h04;
    tick();
    expect_val(1, "deep_fill_2", 5'h1F);
    @(negedge clk);
    data_in_d = 5'h05;
    tick();
    expect_val(1, "deep_out_03", 5'h03);
    @(negedge clk);
    data_in_d = 5'h00;
    tick();
    expect_val(1, "deep_out_04", 5'h04);
    tick();
    expect_val(1, "deep_out_05", 5'h05);

    // Every expectation must have been consumed by the monitor.
    #1;
    n_total++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_5bit.md
Name: register_5bit

Overview:
- Clocked data register, 5 bits wide by default, that holds `data_in` and presents it on `data_out`.
- Used as a pipeline or holding register between combinational datapath blocks.
- Optional extra pipeline depth, a programmable reset value, and an optional even-parity output.
- Captures on every rising clock edge; no enable.

Parameters:
- WIDTH, 5, data width in bits (minimum 1).
- DEPTH, 1, number of cascaded register stages (minimum 1); sets the latency.
- RESET_VAL, 0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-low (0 = reset asserted).
- data_in  input  WIDTH  data to capture.
- data_out  output  WIDTH  registered data, last stage of the chain.
- parity_out  output  1  even parity of `data_out`; present only with REGISTER_5BIT_PARITY_EN.

Behaviour:
- Reset, assertion:
  - When `rst` falls to 0, every stage and `data_out` take RESET_VAL immediately, without waiting for a clock edge.
  - They hold RESET_VAL for as long as `rst` = 0, and clock edges are ignored.
- Reset, release:
  - `rst` rises to 1 asynchronously.
  - The first capture happens at the first rising `clk` edge strictly after release.
  - A `clk` edge coincident with release is treated as still in reset, so no capture.
- Normal operation:
  - At each rising edge with `rst` = 1, stage0 <= `data_in` and stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - `data_out` = stage[DEPTH-1].
- Latency:
  - `data_in` sampled at edge N appears on `data_out` after edge N + DEPTH - 1.
  - With the default DEPTH = 1, `data_out` shows the value just after the capturing edge.
  - Throughput is one word per cycle.
- Hold: no enable. To hold a value, `data_in` must be held constant.
- Width: no arithmetic or truncation. The value passes through bit-exact, MSB = bit WIDTH-1.
- Mid-operation reset: all in-flight stages are discarded to RESET_VAL. After release, the pipeline refills: RESET_VAL is seen at the output for DEPTH-1 further edges.
- `data_in` changing between edges has no effect on `data_out`. The block is glitch-free because the output comes straight from a flop.
- X on `data_in` propagates unchanged. X on `rst` is illegal (simulation assertion when `rst` is X after time 0).
- Elaboration checks: error if WIDTH < 1, DEPTH < 1, or RESET_VAL does not fit in WIDTH bits.

Optional Feature:
- Macro REGISTER_5BIT_PARITY_EN.
- Defined:
  - Port `parity_out` exists and equals the XOR of all bits of `data_out`, registered alongside the last stage so it has the same latency.
  - Reset value = XOR of RESET_VAL (0 for the default).
- Not defined: the port is absent and no parity logic is generated. Core behaviour is identical in both builds.

Decomposition:
- Package register_5bit_pkg: constant REG_DEFAULT_WIDTH = 5, constant REG_DEFAULT_RESET_VAL = '0, and a typedef for the WIDTH-bit data word.
- Sub-module register_stage: one WIDTH-bit flop with async active-low reset to RESET_VAL.
- The top generates DEPTH instances of register_stage in a chain, plus the optional parity flop.

Test Plan:
- Reset at start (DEFAULT params):
  - Stimulus: `rst` = 0, `data_in` = 5'b10110, toggle `clk` for 3 edges.
  - Required: `data_out` = 5'b00000 throughout. Raise `rst`, then the next edge gives `data_out` = 5'b10110.
- Capture sequence with `rst` = 1:
  - Stimulus: drive 5'b00001, 5'b11111, 5'b01010 on successive edges.
  - Required: `data_out` shows each value right after its edge, with no hold or skip.
- Async reset mid-cycle:
  - Stimulus: `data_out` = 5'b11011, then drop `rst` to 0 halfway between edges.
  - Required: `data_out` = 5'b00000 before the next edge. Release `rst` and drive 5'b00100, then the next edge gives 5'b00100.
- Random soak:
  - Stimulus: 20 iterations of random 5-bit `data_in` and random `rst`, changed away from clock edges.
  - Required: a scoreboard model (async clear, capture on posedge) matches `data_out` at every check.
- DEPTH = 3, RESET_VAL = 5'h1F:
  - Stimulus: hold `rst` low, then release and feed 5'h03, 5'h04, 5'h05.
  - Required: during reset, `data_out` = 5'h1F. After release, 5'h1F for the first two edges, then 5'h03, 5'h04, 5'h05.
- REGISTER_5BIT_PARITY_EN defined:
  - Stimulus: `data_in` = 5'b10110 captured.
  - Required: `parity_out` = 1. Then 5'b10100 gives `parity_out` = 0. During reset, `parity_out` = 0.
